// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared AXI types and helpers for the burst address generator and the memory datapaths.
package axi_burst_addr_gen_pkg;

  typedef enum logic [2:0] {
    SIZE_1B   = 3'd0,
    SIZE_2B   = 3'd1,
    SIZE_4B   = 3'd2,
    SIZE_8B   = 3'd3,
    SIZE_16B  = 3'd4,
    SIZE_32B  = 3'd5,
    SIZE_64B  = 3'd6,
    SIZE_128B = 3'd7
  } size_enum_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_enum_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_enum_t;

  typedef logic [1:0]  resp_t;
  // Wide enough for any practical LEN width; narrower lengths are zero-extended.
  typedef logic [31:0] len_t;

  localparam int unsigned AXI_4K_BYTES = 4096;

  function automatic logic [7:0] size_to_bytes(size_enum_t size);
    return 8'd1 << size;
  endfunction

  function automatic logic wrap_len_legal(len_t len);
    return (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen_if.sv
// Command and beat handshake bundle between an AXI slave front end and the burst sequencer.
interface axi_burst_addr_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) ();

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [LEN_WIDTH-1:0]    cmd_len;
  logic [2:0]              cmd_size;
  logic [1:0]              cmd_burst;

  logic                    beat_valid;
  logic                    beat_ready;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic [DATA_WIDTH/8-1:0] beat_strb;
  logic [LEN_WIDTH-1:0]    beat_idx;
  logic                    beat_last;
  logic                    beat_err;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    output cmd_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, beat_err
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    input  cmd_ready, beat_valid, beat_addr, beat_strb, beat_idx, beat_last, beat_err
  );

endinterface

// File: rtl/axi_strb_gen.sv
// Byte-lane strobe for one beat: lanes from the address offset to the end of its 2^size container.
module axi_strb_gen
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int STRB_W    = DATA_WIDTH / 8,
  localparam int OFF_W     = (STRB_W > 1) ? $clog2(STRB_W) : 1
) (
  input  logic [OFF_W-1:0]  addr_lo_i,
  input  logic [2:0]        size_i,
  output logic [STRB_W-1:0] strb_o
);

  logic [31:0] lo;
  logic [31:0] hi;

  // Oversized beats (size wider than the bus) simply fill to the top lane.
  always_comb begin
    strb_o = '0;
    lo     = 32'(addr_lo_i) & 32'(STRB_W - 1);
    hi     = lo | (32'(size_to_bytes(size_enum_t'(size_i))) - 32'd1);
    for (int i = 0; i < STRB_W; i++) begin
      strb_o[i] = (32'(i) >= lo) && (32'(i) <= hi);
    end
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Slave-side AXI burst sequencer: takes one AW/AR command and emits one address/strobe beat per handshake.
module axi_burst_addr_gen
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter bit CHECK_4K   = 1'b1
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  axi_burst_addr_gen_if.slave bus
);

  localparam int         STRB_W   = DATA_WIDTH / 8;
  localparam int         OFF_W    = (STRB_W > 1) ? $clog2(STRB_W) : 1;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));
  localparam int         EXT_W    = ADDR_WIDTH + LEN_WIDTH + 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] wrap_lo_q, wrap_lo_d;
  logic [ADDR_WIDTH-1:0] wrap_end_q, wrap_end_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] cmd_nbytes, cmd_aligned, cmd_span, cmd_wrap_lo;
  logic [EXT_W-1:0]      span_ext, aligned_ext, end_ext;
  logic                  cmd_err;

  logic [ADDR_WIDTH-1:0] cur_nbytes, incr_next, wrap_next;
  logic [STRB_W-1:0]     strb_raw;
  logic                  in_burst, last_beat;

  // Command decode: everything needed to start the burst, including the sticky error.
  always_comb begin
    cmd_nbytes  = ADDR_WIDTH'(size_to_bytes(size_enum_t'(bus.cmd_size)));
    cmd_aligned = bus.cmd_addr & ~(cmd_nbytes - ADDR_WIDTH'(1));
    span_ext    = (EXT_W'(bus.cmd_len) + EXT_W'(1)) * EXT_W'(cmd_nbytes);
    cmd_span    = span_ext[ADDR_WIDTH-1:0];
    cmd_wrap_lo = bus.cmd_addr & ~(cmd_span - ADDR_WIDTH'(1));
    aligned_ext = EXT_W'(cmd_aligned);
    end_ext     = aligned_ext + span_ext - EXT_W'(1);

    cmd_err = 1'b0;
    if (bus.cmd_burst == BURST_RSVD) cmd_err = 1'b1;
    if (bus.cmd_size > MAX_SIZE)     cmd_err = 1'b1;
    if (bus.cmd_burst == BURST_WRAP) begin
      if (!wrap_len_legal(len_t'(bus.cmd_len)))                  cmd_err = 1'b1;
      if ((bus.cmd_addr & (cmd_nbytes - ADDR_WIDTH'(1))) != '0) cmd_err = 1'b1;
    end
    // Page crossing is judged on the last byte touched, computed without address wrap.
    if (CHECK_4K && (bus.cmd_burst == BURST_INCR) &&
        ((end_ext >> 12) != (aligned_ext >> 12))) cmd_err = 1'b1;
  end

  always_comb begin
    cur_nbytes = ADDR_WIDTH'(size_to_bytes(size_enum_t'(size_q)));
    incr_next  = (addr_q & ~(cur_nbytes - ADDR_WIDTH'(1))) + cur_nbytes;
    wrap_next  = addr_q + cur_nbytes;
    if (wrap_next == wrap_end_q) wrap_next = wrap_lo_q;
  end

  assign in_burst  = (state_q == ST_BURST);
  assign last_beat = (idx_q == len_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wrap_lo_d  = wrap_lo_q;
    wrap_end_d = wrap_end_q;
    len_d      = len_q;
    idx_d      = idx_q;
    size_d     = size_q;
    burst_d    = burst_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_d    = ST_BURST;
          addr_d     = bus.cmd_addr;
          wrap_lo_d  = cmd_wrap_lo;
          wrap_end_d = cmd_wrap_lo + cmd_span;
          len_d      = bus.cmd_len;
          idx_d      = '0;
          size_d     = bus.cmd_size;
          burst_d    = bus.cmd_burst;
          err_d      = cmd_err;
        end
      end
      default: begin
        if (bus.beat_ready) begin
          if (last_beat) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + LEN_WIDTH'(1);
            case (burst_q)
              BURST_FIXED: addr_d = addr_q;
              BURST_WRAP:  addr_d = wrap_next;
              default:     addr_d = incr_next;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wrap_lo_q  <= '0;
      wrap_end_q <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wrap_lo_q  <= wrap_lo_d;
      wrap_end_q <= wrap_end_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      err_q      <= err_d;
    end
  end

  axi_strb_gen #(.DATA_WIDTH(DATA_WIDTH)) u_strb_gen (
    .addr_lo_i (addr_q[OFF_W-1:0]),
    .size_i    (size_q),
    .strb_o    (strb_raw)
  );

  assign bus.cmd_ready  = !in_burst;
  assign bus.beat_valid = in_burst;
  assign bus.beat_addr  = addr_q;
  assign bus.beat_strb  = in_burst ? strb_raw : '0;
  assign bus.beat_idx   = idx_q;
  assign bus.beat_last  = in_burst && last_beat;
  assign bus.beat_err   = in_burst && err_q;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed bench for axi_burst_addr_gen on a 32-bit bus with 4 KB checking enabled.
module tb_axi_burst_addr_gen;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 ACLK = ~ACLK;

  axi_burst_addr_gen_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) bus ();

  axi_burst_addr_gen #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8), .CHECK_4K(1'b1)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_size  = size;
    bus.cmd_burst = burst;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    chk("beat_valid_lat1", 64'(bus.beat_valid), 64'd1);
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] ea, input logic [3:0] es,
                             input logic [7:0] ei, input logic el, input logic ee,
                             input bit chk_as);
    chk({tag, ".valid"}, 64'(bus.beat_valid), 64'd1);
    if (chk_as) begin
      chk({tag, ".addr"}, 64'(bus.beat_addr), 64'(ea));
      chk({tag, ".strb"}, 64'(bus.beat_strb), 64'(es));
    end
    chk({tag, ".idx"},  64'(bus.beat_idx),  64'(ei));
    chk({tag, ".last"}, 64'(bus.beat_last), 64'(el));
    chk({tag, ".err"},  64'(bus.beat_err),  64'(ee));
  endtask

  task automatic take_beat(input string tag, input logic [31:0] ea, input logic [3:0] es,
                           input logic [7:0] ei, input logic el, input logic ee,
                           input bit chk_as);
    expect_beat(tag, ea, es, ei, el, ee, chk_as);
    bus.beat_ready = 1'b1;
    tick();
    bus.beat_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".cmd_ready"},  64'(bus.cmd_ready),  64'd1);
    chk({tag, ".beat_valid"}, 64'(bus.beat_valid), 64'd0);
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_len    = '0;
    bus.cmd_size   = '0;
    bus.cmd_burst  = '0;
    bus.beat_ready = 1'b0;

    repeat (3) tick();
    chk("rst.cmd_ready",  64'(bus.cmd_ready),  64'd1);
    chk("rst.beat_valid", 64'(bus.beat_valid), 64'd0);
    chk("rst.addr",       64'(bus.beat_addr),  64'd0);
    chk("rst.strb",       64'(bus.beat_strb),  64'd0);
    chk("rst.idx",        64'(bus.beat_idx),   64'd0);
    chk("rst.last",       64'(bus.beat_last),  64'd0);
    chk("rst.err",        64'(bus.beat_err),   64'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick();

    // INCR aligned
    send_cmd(32'h1000, 8'd3, 3'd2, 2'b01);
    take_beat("incr_a0", 32'h1000, 4'hF, 8'd0, 1'b0, 1'b0, 1'b1);
    take_beat("incr_a1", 32'h1004, 4'hF, 8'd1, 1'b0, 1'b0, 1'b1);
    take_beat("incr_a2", 32'h1008, 4'hF, 8'd2, 1'b0, 1'b0, 1'b1);
    take_beat("incr_a3", 32'h100C, 4'hF, 8'd3, 1'b1, 1'b0, 1'b1);
    check_idle("incr_a_bubble");

    // INCR unaligned start
    send_cmd(32'h1002, 8'd1, 3'd2, 2'b01);
    take_beat("incr_u0", 32'h1002, 4'hC, 8'd0, 1'b0, 1'b0, 1'b1);
    take_beat("incr_u1", 32'h1004, 4'hF, 8'd1, 1'b1, 1'b0, 1'b1);

    // WRAP legal
    send_cmd(32'h38, 8'd3, 3'd2, 2'b10);
    take_beat("wrap0", 32'h38, 4'hF, 8'd0, 1'b0, 1'b0, 1'b1);
    take_beat("wrap1", 32'h3C, 4'hF, 8'd1, 1'b0, 1'b0, 1'b1);
    take_beat("wrap2", 32'h30, 4'hF, 8'd2, 1'b0, 1'b0, 1'b1);
    take_beat("wrap3", 32'h34, 4'hF, 8'd3, 1'b1, 1'b0, 1'b1);

    // WRAP illegal length: first beat address is the command address, rest don't-care
    send_cmd(32'h38, 8'd2, 3'd2, 2'b10);
    take_beat("wrapbad0", 32'h38, 4'hF, 8'd0, 1'b0, 1'b1, 1'b1);
    take_beat("wrapbad1", 32'h0,  4'h0, 8'd1, 1'b0, 1'b1, 1'b0);
    take_beat("wrapbad2", 32'h0,  4'h0, 8'd2, 1'b1, 1'b1, 1'b0);
    check_idle("wrapbad_end");

    // FIXED with a 4-cycle stall on beat 1
    send_cmd(32'h201, 8'd2, 3'd0, 2'b00);
    take_beat("fixed0", 32'h201, 4'h2, 8'd0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      expect_beat($sformatf("fixed_stall%0d", c), 32'h201, 4'h2, 8'd1, 1'b0, 1'b0, 1'b1);
      tick();
    end
    take_beat("fixed1", 32'h201, 4'h2, 8'd1, 1'b0, 1'b0, 1'b1);
    take_beat("fixed2", 32'h201, 4'h2, 8'd2, 1'b1, 1'b0, 1'b1);

    // INCR across a 4 KB page
    send_cmd(32'h0FF8, 8'd3, 3'd2, 2'b01);
    take_beat("pg0", 32'h0FF8, 4'hF, 8'd0, 1'b0, 1'b1, 1'b1);
    take_beat("pg1", 32'h0FFC, 4'hF, 8'd1, 1'b0, 1'b1, 1'b1);
    take_beat("pg2", 32'h1000, 4'hF, 8'd2, 1'b0, 1'b1, 1'b1);
    take_beat("pg3", 32'h1004, 4'hF, 8'd3, 1'b1, 1'b1, 1'b1);

    // Beat wider than the bus; len=0 is last on beat 0
    send_cmd(32'h0, 8'd0, 3'd3, 2'b01);
    take_beat("size8", 32'h0, 4'h0, 8'd0, 1'b1, 1'b1, 1'b0);

    // RESERVED burst type
    send_cmd(32'h100, 8'd1, 3'd2, 2'b11);
    take_beat("rsvd0", 32'h100, 4'hF, 8'd0, 1'b0, 1'b1, 1'b1);
    take_beat("rsvd1", 32'h0,   4'h0, 8'd1, 1'b1, 1'b1, 1'b0);

    // Reset during beat 1 of a 4-beat burst
    send_cmd(32'h2000, 8'd3, 3'd2, 2'b01);
    take_beat("rb0", 32'h2000, 4'hF, 8'd0, 1'b0, 1'b0, 1'b1);
    expect_beat("rb1", 32'h2004, 4'hF, 8'd1, 1'b0, 1'b0, 1'b1);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("midrst.cmd_ready",  64'(bus.cmd_ready),  64'd1);
    chk("midrst.beat_valid", 64'(bus.beat_valid), 64'd0);
    chk("midrst.addr",       64'(bus.beat_addr),  64'd0);
    chk("midrst.strb",       64'(bus.beat_strb),  64'd0);
    chk("midrst.idx",        64'(bus.beat_idx),   64'd0);
    chk("midrst.last",       64'(bus.beat_last),  64'd0);
    chk("midrst.err",        64'(bus.beat_err),   64'd0);
    repeat (2) tick();
    @(negedge ACLK);
    ARESETn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_idle($sformatf("postrst%0d", c));
    end

    send_cmd(32'h40, 8'd0, 3'd2, 2'b01);
    take_beat("after_rst", 32'h40, 4'hF, 8'd0, 1'b1, 1'b0, 1'b1);
    check_idle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_burst_addr_gen.md
Name: axi_burst_addr_gen

Overview:
- Slave-side AXI burst sequencer shared by the dual-port memory's read and write channels.
- Accepts one AW/AR-style command (addr, len, size, burst).
- Emits one beat per handshake: address, byte-lane strobe, beat index, last flag and an error flag.
- Generalises the fixed-width burst decoding to any data width, any LEN width and all three burst modes, including WRAP, unaligned INCR start and 4 KB boundary checking.

Parameters:
- ADDR_WIDTH, 32, address bits.
- DATA_WIDTH, 32, bus width in bits; power of two, 8..1024.
- LEN_WIDTH, 8, AxLEN bits; beats = len+1.
- CHECK_4K, 1, when 1 an INCR burst crossing a 4 KB page is flagged as an error.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_len  in  LEN_WIDTH  beats minus one.
- cmd_size  in  3  bytes per beat = 2^size.
- cmd_burst  in  2  FIXED/INCR/WRAP/RESERVED.
- beat_valid  out  1  beat available.
- beat_ready  in  1  consumer takes beat.
- beat_addr  out  ADDR_WIDTH  address of current beat.
- beat_strb  out  DATA_WIDTH/8  active byte lanes.
- beat_idx  out  LEN_WIDTH  beat number, 0-based.
- beat_last  out  1  final beat of burst.
- beat_err  out  1  burst illegal; consumer returns SLVERR and suppresses memory access.

Behaviour:
- Reset (ARESETn low, asynchronous): state=IDLE, cmd_ready=1, beat_valid=0, beat_addr=0, beat_strb=0, beat_idx=0, beat_last=0, beat_err=0.
- A reset asserted mid-burst abandons the burst. No beat is emitted after reset release until a new command is accepted.
- FSM states: IDLE and BURST.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch the command, compute beat 0 and go to BURST.
  - BURST: cmd_ready=0, beat_valid=1. beat_valid first rises the cycle after the command handshake (latency 1).
  - BURST holds all beat outputs stable while beat_valid&&!beat_ready.
  - On beat handshake with beat_last=1, go to IDLE; cmd_ready rises the next cycle. There is one bubble cycle between bursts.
  - On beat handshake with beat_last=0: beat_idx+1 and the next address/strobe appear the next cycle.
- beat_last = (beat_idx == latched len). For len=0, beat 0 is last.
- Address rules, with N = 2^size bytes and A = aligned start = addr & ~(N-1):
  - FIXED: every beat uses the original addr and the same strb.
  - INCR: beat 0 uses addr; beat k uses A + k*N. Address arithmetic wraps modulo 2^ADDR_WIDTH without a flag.
  - WRAP: span T = N*(len+1); lower bound W = addr & ~(T-1). Next = cur+N; if next == W+T, then next = W.
- Strobe: lanes from (beat_addr mod DATA_WIDTH/8) up to the end of the N-byte container holding beat_addr. An unaligned first beat therefore gets a partial mask.
- beat_err is evaluated once at command accept and held for every beat of the burst. It is set when any of these holds:
  - burst == RESERVED;
  - N > DATA_WIDTH/8;
  - WRAP with len not in {1,3,7,15};
  - WRAP with addr not N-aligned;
  - CHECK_4K=1, INCR, and A + (len+1)*N crosses a 4 KB page.
- Errored bursts still produce exactly len+1 beats, so the handshake count is preserved. beat_addr/strb follow the normal rules and are don't-care to the consumer.
- A cmd_valid arriving during BURST is ignored (cmd_ready=0). The command must be held by the master per the AXI valid rule.

Decomposition:
- Add to the shared AXI package:
  - resp_t/resp_enum_t (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11);
  - constant AXI_4K_BYTES=4096;
  - function size_to_bytes(size_enum_t);
  - function wrap_len_legal(len_t).
- Reuse the existing size_enum_t and burst_enum_t.
- One combinational sub-module, axi_strb_gen (addr low bits, size -> strb), parametrised by DATA_WIDTH and reused by the write datapath.

Test Plan (DATA_WIDTH=32):
- INCR addr=0x1000, len=3, size=2 -> beat addrs 0x1000/04/08/0C, strb 0xF each, last only on idx 3, err=0.
- INCR addr=0x1002, len=1, size=2 -> beat0 addr 0x1002 strb 0xC; beat1 addr 0x1004 strb 0xF.
- WRAP addr=0x38, len=3, size=2 -> addrs 0x38, 0x3C, 0x30, 0x34; err=0. Same burst with len=2 -> 3 beats, err=1 on all.
- FIXED addr=0x201, len=2, size=0 -> three beats at 0x201, strb 0x2; beat_ready held low 4 cycles mid-burst -> outputs stable throughout.
- INCR addr=0x0FF8, len=3, size=2 with CHECK_4K=1 -> err=1 on all 4 beats. size=3 on the 32-bit bus -> err=1. burst=RESERVED -> err=1.
- Reset pulsed low during beat 1 of a 4-beat burst -> outputs return to reset values immediately, cmd_ready=1 after release, no stray beat.
